riscv_serial_divider: RTL and testbench

Iterative 32-bit integer divider/remainder unit in the EX stage, directly downstream of the ID-stage decoder. Accepts `ALU_DIVU`/`ALU_DIV`/`ALU_REMU`/`ALU_REM` operations issued by the decoder through a valid/ready handshake. Computes one quotient bit per cycle using restoring division, then holds the result until the EX/WB stage accepts it. Divide-by-zero and signed overflow are resolved early, following RISC-V M-extension semantics.

---
 rtl/riscv_serial_divider.sv | 149 ++++++++++++++
 tb/tb_riscv_serial_divider.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/riscv_serial_divider.sv
// riscv_serial_divider: iterative 32-bit DIV/DIVU/REM/REMU unit for the EX stage.
// Restoring division produces one quotient bit per cycle. Divide-by-zero and
// signed overflow skip the iteration and complete in one cycle. The result is
// held in DONE until the EX/WB stage takes it.
module riscv_serial_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_valid_i,
    input  logic [5:0]       operator_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    output logic             div_ready_o,
    input  logic             flush_i,
    output logic             result_valid_o,
    output logic [WIDTH-1:0] result_o,
    input  logic             ex_ready_i
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Two's complement negation, used for operand magnitudes and sign fix-up.
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    state_e           state_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] dividend_r;   // shifts out dividend bits, shifts in quotient bits
    logic [WIDTH-1:0] divisor_r;
    logic [WIDTH-1:0] rem_r;
    logic             neg_q_r;
    logic             neg_r_r;
    logic             rem_op_r;
    logic [WIDTH-1:0] result_r;

    logic             accept_s;
    logic             div_zero_s;
    logic             overflow_s;
    logic [WIDTH-1:0] special_res_s;
    logic [WIDTH:0]   rem_shift_s;
    logic [WIDTH:0]   diff_s;
    logic             qbit_s;
    logic [WIDTH-1:0] rem_next_s;
    logic [WIDTH-1:0] quot_next_s;
    logic [WIDTH-1:0] final_res_s;

    assign div_ready_o    = (state_r == IDLE);
    assign result_valid_o = (state_r == DONE);
    assign result_o       = result_r;

    // Accept decode, early special-case detection and one restoring step.
    always_comb begin
        accept_s      = div_valid_i & (state_r == IDLE) &
                        (operator_i[5:2] == 4'b1100) & ~flush_i;
        div_zero_s    = (op_b_i == {WIDTH{1'b0}});
        overflow_s    = operator_i[0] &
                        (op_a_i == {1'b1, {(WIDTH-1){1'b0}}}) &
                        (op_b_i == {WIDTH{1'b1}});
        special_res_s = {WIDTH{1'b0}};
        if (div_zero_s) begin
            special_res_s = operator_i[1] ? op_a_i : {WIDTH{1'b1}};
        end else if (overflow_s) begin
            special_res_s = operator_i[1] ? {WIDTH{1'b0}} : {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            special_res_s = {WIDTH{1'b0}};
        end

        // The partial remainder stays below the divisor, so WIDTH+1 bits
        // hold the shifted value and the sign of the trial subtraction.
        rem_shift_s = {rem_r, dividend_r[WIDTH-1]};
        diff_s      = rem_shift_s - {1'b0, divisor_r};
        qbit_s      = ~diff_s[WIDTH];
        if (qbit_s) begin
            rem_next_s = diff_s[WIDTH-1:0];
        end else begin
            rem_next_s = rem_shift_s[WIDTH-1:0];
        end
        quot_next_s = {dividend_r[WIDTH-2:0], qbit_s};

        if (rem_op_r) begin
            final_res_s = neg_r_r ? negate(rem_next_s) : rem_next_s;
        end else begin
            final_res_s = neg_q_r ? negate(quot_next_s) : quot_next_s;
        end
    end

    // Control FSM plus datapath registers; flush overrides accept and handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= {CW{1'b0}};
            dividend_r <= {WIDTH{1'b0}};
            divisor_r  <= {WIDTH{1'b0}};
            rem_r      <= {WIDTH{1'b0}};
            neg_q_r    <= 1'b0;
            neg_r_r    <= 1'b0;
            rem_op_r   <= 1'b0;
            result_r   <= {WIDTH{1'b0}};
        end else if (flush_i) begin
            state_r <= IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        if (div_zero_s || overflow_s) begin
                            result_r <= special_res_s;
                            state_r  <= DONE;
                        end else begin
                            dividend_r <= (operator_i[0] && op_a_i[WIDTH-1]) ? negate(op_a_i) : op_a_i;
                            divisor_r  <= (operator_i[0] && op_b_i[WIDTH-1]) ? negate(op_b_i) : op_b_i;
                            rem_r      <= {WIDTH{1'b0}};
                            neg_q_r    <= operator_i[0] & (op_a_i[WIDTH-1] ^ op_b_i[WIDTH-1]);
                            neg_r_r    <= operator_i[0] & op_a_i[WIDTH-1];
                            rem_op_r   <= operator_i[1];
                            cnt_r      <= {CW{1'b0}};
                            state_r    <= CALC;
                        end
                    end
                end
                CALC: begin
                    dividend_r <= quot_next_s;
                    rem_r      <= rem_next_s;
                    cnt_r      <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    if (cnt_r == CW'(WIDTH-1)) begin
                        result_r <= final_res_s;
                        state_r  <= DONE;
                    end
                end
                DONE: begin
                    if (ex_ready_i) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_serial_divider.sv
// Directed bench for riscv_serial_divider: hand-computed vectors, latency,
// backpressure, flush, mid-operation reset and ignored operators.
module tb_riscv_serial_divider;

    localparam logic [5:0] OP_DIVU = 6'b110000;
    localparam logic [5:0] OP_DIV  = 6'b110001;
    localparam logic [5:0] OP_REMU = 6'b110010;
    localparam logic [5:0] OP_REM  = 6'b110011;
    localparam logic [5:0] OP_ADD  = 6'b011000;

    logic        clk;
    logic        rst;
    logic        div_valid;
    logic [5:0]  operator;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        div_ready;
    logic        flush;
    logic        result_valid;
    logic [31:0] result;
    logic        ex_ready;

    int n_cmp;
    int n_err;

    riscv_serial_divider #(.WIDTH(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .div_valid_i    (div_valid),
        .operator_i     (operator),
        .op_a_i         (op_a),
        .op_b_i         (op_b),
        .div_ready_o    (div_ready),
        .flush_i        (flush),
        .result_valid_o (result_valid),
        .result_o       (result),
        .ex_ready_i     (ex_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation from IDLE, check latency/result, hold for 'hold'
    // cycles with ex_ready low, then complete the handshake.
    task automatic run_op(input string tag, input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp,
                          input int exp_lat, input int hold);
        int lat;
        div_valid = 1'b1;
        operator  = op;
        op_a      = a;
        op_b      = b;
        tick();
        div_valid = 1'b0;
        lat = 0;
        while (!result_valid && lat < 40) begin
            check_eq({tag, "_busy_ready"}, {31'd0, div_ready}, 32'd0);
            tick();
            lat++;
        end
        check_eq({tag, "_latency"}, lat, exp_lat);
        check_eq({tag, "_done_ready"}, {31'd0, div_ready}, 32'd0);
        check_eq({tag, "_result"}, result, exp);
        for (int i = 0; i < hold; i++) begin
            tick();
            check_eq({tag, "_hold_valid"}, {31'd0, result_valid}, 32'd1);
            check_eq({tag, "_hold_result"}, result, exp);
        end
        ex_ready = 1'b1;
        tick();
        ex_ready = 1'b0;
        check_eq({tag, "_post_ready"}, {31'd0, div_ready}, 32'd1);
        check_eq({tag, "_post_valid"}, {31'd0, result_valid}, 32'd0);
    endtask

    initial begin
        int seen;
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        div_valid = 1'b0;
        operator  = 6'd0;
        op_a      = 32'd0;
        op_b      = 32'd0;
        flush     = 1'b0;
        ex_ready  = 1'b0;
        tick();
        tick();
        check_eq("rst_ready", {31'd0, div_ready}, 32'd1);
        check_eq("rst_valid", {31'd0, result_valid}, 32'd0);
        check_eq("rst_result", result, 32'd0);
        rst = 1'b0;
        tick();

        // Normal operations.
        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 32, 0);
        run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 32, 0);
        run_op("div_m7_2",   OP_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32, 0);
        run_op("rem_m7_2",   OP_REM,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32, 0);
        run_op("rem_7_m2",   OP_REM,  32'd7, 32'hFFFFFFFE, 32'd1, 32, 0);
        run_op("div_100_m7", OP_DIV,  32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32, 0);
        run_op("divu_max_10", OP_DIVU, 32'hFFFFFFFF, 32'd10, 32'h19999999, 32, 0);
        run_op("remu_max_10", OP_REMU, 32'hFFFFFFFF, 32'd10, 32'd5, 32, 0);

        // Divide by zero.
        run_op("divu_5_0", OP_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 0, 0);
        run_op("remu_5_0", OP_REMU, 32'd5, 32'd0, 32'd5, 0, 0);
        run_op("div_m5_0", OP_DIV,  32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 0, 0);
        run_op("rem_m5_0", OP_REM,  32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 0, 0);

        // Signed overflow, and the same operands unsigned.
        run_op("div_ovf",  OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 0);
        run_op("rem_ovf",  OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'd0, 0, 0);
        run_op("divu_ovf", OP_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32, 0);

        // Backpressure, then an immediate follow-on operation.
        run_op("bp_divu", OP_DIVU, 32'd1000, 32'd10, 32'd100, 32, 10);
        run_op("bp_next", OP_REMU, 32'd1001, 32'd10, 32'd1, 32, 0);

        // Flush at T+10: idle at T+11 and no result ever appears.
        div_valid = 1'b1;
        operator  = OP_DIVU;
        op_a      = 32'd77;
        op_b      = 32'd3;
        tick();
        div_valid = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("flush_ready", {31'd0, div_ready}, 32'd1);
        check_eq("flush_valid", {31'd0, result_valid}, 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (result_valid) seen++;
            tick();
        end
        check_eq("flush_no_result", seen, 32'd0);

        // Reset asserted at T+5 during calculation; result register holds 1 beforehand.
        div_valid = 1'b1;
        operator  = OP_DIVU;
        op_a      = 32'd50;
        op_b      = 32'd5;
        tick();
        div_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        #1;
        check_eq("midrst_ready", {31'd0, div_ready}, 32'd1);
        check_eq("midrst_valid", {31'd0, result_valid}, 32'd0);
        check_eq("midrst_result", result, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        run_op("after_rst", OP_DIVU, 32'd50, 32'd5, 32'd10, 32, 0);

        // Non-divide operator is ignored.
        div_valid = 1'b1;
        operator  = OP_ADD;
        op_a      = 32'd9;
        op_b      = 32'd0;
        tick();
        div_valid = 1'b0;
        check_eq("add_ready", {31'd0, div_ready}, 32'd1);
        check_eq("add_valid", {31'd0, result_valid}, 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (result_valid || !div_ready) seen++;
            tick();
        end
        check_eq("add_ignored", seen, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
